agp32_mem_responder: RTL

- Memory-side responder for the agp32 core's instruction/data memory protocol.
- Accepts the core's 3-bit `command` pulses, performs the word or byte-strobed access on an internal word array, and fetches the instruction at `PC` with every command.
- Signals completion on `ready`, signals startup on `mem_start_ready`, and reports faults on `error`.
- Sits between the core and the board-level memory; used as the simulation/FPGA memory model for the pipeline benchmarks.

---
 rtl/agp32_mem_responder_pkg.sv | 29 ++
 rtl/agp32_mem_responder_bank.sv | 35 +++
 rtl/agp32_mem_responder.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/agp32_mem_responder_pkg.sv
// agp32_mem_pkg: shared command, error and state encodings for the agp32
// memory responder and its storage bank.
package agp32_mem_pkg;

    typedef enum logic [2:0] {
        NONE  = 3'd0,
        FETCH = 3'd1,
        READ  = 3'd2,
        WRITE = 3'd3,
        FLUSH = 3'd4
    } mem_cmd_t;

    typedef enum logic [1:0] {
        OK       = 2'd0,
        BAD_STRB = 2'd1,
        OOR      = 2'd2,
        BAD_CMD  = 2'd3
    } mem_err_t;

    typedef enum logic [1:0] {
        INIT = 2'd0,
        IDLE = 2'd1,
        BUSY = 2'd2
    } resp_state_t;

    // Instruction returned when there is nothing valid to fetch.
    localparam logic [31:0] NOP_INSTR = 32'd63;

endpackage

// File: rtl/agp32_mem_responder_bank.sv
// agp32_mem_bank: DEPTH_WORDS x 32 word array with one byte-strobed write
// port and two combinational read ports (instruction and data). Contents are
// never reset.
module agp32_mem_bank #(
    parameter int DEPTH_WORDS = 1024,
    parameter int AW          = 10
) (
    input  logic          clk,
    input  logic          we,
    input  logic [3:0]    wstrb,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] inst_addr,
    output logic [31:0]   inst_rdata,
    input  logic [AW-1:0] data_addr,
    output logic [31:0]   data_rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    // Byte-strobed write; indices past the array end (non power-of-two depth) are dropped.
    always_ff @(posedge clk) begin
        if (we && (32'(waddr) < 32'(DEPTH_WORDS))) begin
            for (int i = 0; i < 4; i++) begin
                if (wstrb[i]) begin
                    mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    assign inst_rdata = (32'(inst_addr) < 32'(DEPTH_WORDS)) ? mem[inst_addr] : '0;
    assign data_rdata = (32'(data_addr) < 32'(DEPTH_WORDS)) ? mem[data_addr] : '0;

endmodule

// File: rtl/agp32_mem_responder.sv
// agp32_mem_responder: memory-side responder for the agp32 core. Accepts a
// one-cycle command pulse, holds ready low for LATENCY cycles, then performs
// the word/byte access and the instruction fetch at PC. Faults are reported
// on a sticky error code.
// Optional: define AGP32_MEM_PERF_CNT_EN to add saturating fetch/read/write
// completion counters.
module agp32_mem_responder
    import agp32_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2,
    parameter int INIT_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  command,
    input  logic [31:0] PC,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    input  logic [3:0]  data_wstrb,
    output logic        ready,
    output logic [31:0] inst_rdata,
    output logic [31:0] data_rdata,
    output logic        mem_start_ready,
    output logic [1:0]  error
`ifdef AGP32_MEM_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetches,
    output logic [31:0] perf_reads,
    output logic [31:0] perf_writes
`endif
);

    localparam int          AW         = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [32:0] ADDR_LIMIT = 33'(DEPTH_WORDS) << 2;

    resp_state_t state;
    logic [31:0] cnt;

    // Request captured at accept; only meaningful while BUSY.
    mem_cmd_t    cmd_p0;
    logic [31:0] pc_p0;
    logic [31:0] addr_p0;
    logic [31:0] wdata_p0;
    logic [3:0]  wstrb_p0;

    logic        accept;
    logic        complete;
    logic        pc_ok;
    logic        addr_ok;
    logic        bank_we;
    logic        same_word;
    logic [31:0] inst_word;
    logic [31:0] data_word;
    logic [31:0] merged;

    function automatic logic in_range(input logic [31:0] a);
        return {1'b0, a} < ADDR_LIMIT;
    endfunction

    // Error classification at accept, highest priority first.
    function automatic mem_err_t accept_err(input logic [2:0]  c,
                                            input logic [31:0] pc,
                                            input logic [31:0] da,
                                            input logic [3:0]  ws);
        if (c > 3'd4)
            return BAD_CMD;
        if (!in_range(pc) || (((c == 3'(READ)) || (c == 3'(WRITE))) && !in_range(da)))
            return OOR;
        if ((c == 3'(WRITE)) && (ws == 4'd0))
            return BAD_STRB;
        return OK;
    endfunction

    assign accept    = (state == IDLE) && (command != 3'd0);
    assign complete  = (state == BUSY) && (cnt == 32'd0);
    assign pc_ok     = in_range(pc_p0);
    assign addr_ok   = in_range(addr_p0);
    assign bank_we   = complete && (cmd_p0 == WRITE) && addr_ok && (wstrb_p0 != 4'd0);
    assign same_word = (pc_p0[31:2] == addr_p0[31:2]);

    // Latch the request on accept; illegal commands are carried as NONE.
    always_ff @(posedge clk) begin
        if (accept) begin
            cmd_p0   <= (command > 3'd4) ? NONE : mem_cmd_t'(command);
            pc_p0    <= PC;
            addr_p0  <= data_addr;
            wdata_p0 <= data_wdata;
            wstrb_p0 <= data_wstrb;
        end
    end

    // Word as it will look after this write, used to make the fetch write-first.
    always_comb begin
        merged = data_word;
        for (int i = 0; i < 4; i++) begin
            if (wstrb_p0[i]) begin
                merged[8*i +: 8] = wdata_p0[8*i +: 8];
            end
        end
    end

    agp32_mem_bank #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_bank (
        .clk        (clk),
        .we         (bank_we),
        .wstrb      (wstrb_p0),
        .waddr      (addr_p0[AW+1:2]),
        .wdata      (wdata_p0),
        .inst_addr  (pc_p0[AW+1:2]),
        .inst_rdata (inst_word),
        .data_addr  (addr_p0[AW+1:2]),
        .data_rdata (data_word)
    );

    // Protocol FSM: startup count, accept, latency countdown and completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= INIT;
            cnt             <= '0;
            ready           <= 1'b0;
            mem_start_ready <= 1'b0;
            error           <= 2'd0;
            inst_rdata      <= NOP_INSTR;
            data_rdata      <= '0;
        end else begin
            case (state)
                INIT: begin
                    if (cnt + 32'd1 >= 32'(INIT_CYCLES)) begin
                        cnt             <= '0;
                        ready           <= 1'b1;
                        mem_start_ready <= 1'b1;
                        state           <= IDLE;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                IDLE: begin
                    if (accept) begin
                        ready <= 1'b0;
                        cnt   <= 32'(LATENCY - 1);
                        state <= BUSY;
                        if (error == 2'd0) begin
                            error <= accept_err(command, PC, data_addr, data_wstrb);
                        end
                    end
                end
                BUSY: begin
                    if (cnt == 32'd0) begin
                        if (cmd_p0 != NONE) begin
                            if (!pc_ok)
                                inst_rdata <= NOP_INSTR;
                            else if (bank_we && same_word)
                                inst_rdata <= merged;
                            else
                                inst_rdata <= inst_word;
                        end
                        if (cmd_p0 == READ) begin
                            data_rdata <= addr_ok ? data_word : '0;
                        end
                        ready <= 1'b1;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - 32'd1;
                    end
                end
                default: begin
                    state <= INIT;
                    cnt   <= '0;
                    ready <= 1'b0;
                end
            endcase
        end
    end

`ifdef AGP32_MEM_PERF_CNT_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // Completion counters; every non-NONE command also performs a fetch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetches <= '0;
            perf_reads   <= '0;
            perf_writes  <= '0;
        end else if (complete) begin
            if (cmd_p0 != NONE)  perf_fetches <= sat_inc(perf_fetches);
            if (cmd_p0 == READ)  perf_reads   <= sat_inc(perf_reads);
            if (cmd_p0 == WRITE) perf_writes  <= sat_inc(perf_writes);
        end
    end
`endif

endmodule
